// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared constants and types for the iterative shifters of the 32-bit
// R-type datapath.
//   WIDTH       : operand/result width
//   SHW         : shift-amount width (log2 WIDTH)
//   shl_state_t : control states of the iterative left shifter
// ---------------------------------------------------------------------------
package shift_pkg;

   localparam int WIDTH = 32;
   localparam int SHW   = 5;

   // Two-bit encoding; the fourth code is unused and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } shl_state_t;

endpackage : shift_pkg

// File: rtl/mux2to1.sv
// ---------------------------------------------------------------------------
// mux2to1
// Single-bit two-input multiplexer, the leaf cell of the shift levels.
// Ports:
//   a0  in  : selected when sel = 0
//   a1  in  : selected when sel = 1
//   sel in  : select
//   y   out : multiplexer output
// ---------------------------------------------------------------------------
module mux2to1 (
   input  logic a0,
   input  logic a1,
   input  logic sel,
   output logic y
);

   assign y = sel ? a1 : a0;

endmodule : mux2to1

// File: rtl/shl1_level.sv
// ---------------------------------------------------------------------------
// shl1_level
// One left-shift-by-one mux level: m = s ? {a[WIDTH-2:0], 1'b0} : a.
// Mirror of the right-shift level, built from one mux2to1 per bit.
// Ports:
//   a  in  WIDTH : operand
//   s  in  1     : 1 = shift left by one (zero fill), 0 = pass through
//   m  out WIDTH : level output
// ---------------------------------------------------------------------------
module shl1_level #(
   parameter int WIDTH = shift_pkg::WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic             s,
   output logic [WIDTH-1:0] m
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i == 0) begin : g_lsb
         // LSB receives the logical-shift fill bit.
         mux2to1 u_mux (
            .a0  (a[0]),
            .a1  (1'b0),
            .sel (s),
            .y   (m[0])
         );
      end else begin : g_upper
         mux2to1 u_mux (
            .a0  (a[i]),
            .a1  (a[i-1]),
            .sel (s),
            .y   (m[i])
         );
      end
   end

endmodule : shl1_level

// File: rtl/seq_shift_left.sv
// ---------------------------------------------------------------------------
// seq_shift_left
// Iterative logical left shifter (sll/sllv): one bit position per clock
// through a single shl1_level, with a start/busy/done handshake.
// Ports:
//   clk     in  1     : clock, all state on rising edge
//   rst     in  1     : synchronous active-high reset (priority over start)
//   start   in  1     : request, sampled only in IDLE or DONE
//   data_in in  WIDTH : operand, captured on accepted start
//   shamt   in  SHW   : shift amount, captured on accepted start
//   busy    out 1     : registered, high while shifting
//   done    out 1     : registered one-cycle pulse, result valid
//   result  out WIDTH : registered data_in << shamt, held until next done
// ---------------------------------------------------------------------------
module seq_shift_left #(
   parameter int WIDTH = shift_pkg::WIDTH,
   parameter int SHW   = shift_pkg::SHW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic [SHW-1:0]   shamt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   import shift_pkg::*;

   shl_state_t       state_r;
   shl_state_t       next_state_s;
   logic             accept_s;
   logic             shift_s;
   logic [WIDTH-1:0] work_r;
   logic [SHW-1:0]   cnt_r;
   logic [WIDTH-1:0] shifted_s;
   logic [WIDTH-1:0] done_value_s;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] result_r;

   // Single shift level; only enabled while in SHIFT.
   shl1_level #(
      .WIDTH (WIDTH)
   ) u_level (
      .a (work_r),
      .s (shift_s),
      .m (shifted_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic and datapath controls.
   always_comb begin
      next_state_s = IDLE;
      accept_s     = 1'b0;
      shift_s      = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            // DONE accepts exactly like IDLE, giving back-to-back operation.
            if (start) begin
               accept_s = 1'b1;
               if (shamt == {SHW{1'b0}}) begin
                  next_state_s = DONE;
               end else begin
                  next_state_s = SHIFT;
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         SHIFT: begin
            shift_s = 1'b1;
            // Leaving at cnt==1 keeps cnt from ever decrementing past zero.
            if (cnt_r == SHW'(1)) begin
               next_state_s = DONE;
            end else begin
               next_state_s = SHIFT;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Value latched into result on entry to DONE: the operand itself for a
   // zero shift, otherwise the output of the final shift step.
   always_comb begin
      done_value_s = shifted_s;
      if (accept_s) begin
         done_value_s = data_in;
      end else begin
         done_value_s = shifted_s;
      end
   end

   // Datapath registers: working value, remaining count, result, flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         work_r   <= {WIDTH{1'b0}};
         cnt_r    <= {SHW{1'b0}};
         result_r <= {WIDTH{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         if (accept_s) begin
            work_r <= data_in;
            cnt_r  <= shamt;
         end else if (shift_s) begin
            work_r <= shifted_s;
            cnt_r  <= cnt_r - SHW'(1);
         end else begin
            work_r <= work_r;
            cnt_r  <= cnt_r;
         end
         if (next_state_s == DONE) begin
            result_r <= done_value_s;
         end else begin
            result_r <= result_r;
         end
         busy_r <= (next_state_s == SHIFT);
         done_r <= (next_state_s == DONE);
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = result_r;

endmodule : seq_shift_left

// File: tb/tb_seq_shift_left.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_left
// Directed self-checking bench for seq_shift_left.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// "Latency" below counts edges after the edge that samples start.
// ---------------------------------------------------------------------------
module tb_seq_shift_left;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] data_in;
   logic [4:0]  shamt;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int errors;
   int checks;

   seq_shift_left #(
      .WIDTH (32),
      .SHW   (5)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .data_in (data_in),
      .shamt   (shamt),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation from IDLE and check latency, busy length, result.
   task automatic run_op(input string tag, input logic [31:0] d, input int sh,
                         input logic [31:0] exp);
      int lat;
      int busy_cnt;
      start   = 1'b1;
      data_in = d;
      shamt   = 5'(sh);
      tick();
      start   = 1'b0;
      data_in = 32'hDEAD_BEEF;
      shamt   = 5'd7;
      lat      = 0;
      busy_cnt = 0;
      while (done !== 1'b1 && lat < 64) begin
         if (busy === 1'b1) busy_cnt++;
         tick();
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(sh));
      check({tag, "_busy"}, 32'(busy_cnt), 32'(sh));
      check({tag, "_res"}, result, exp);
      check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
      tick();
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_hold"}, result, exp);
   endtask

   initial begin
      int dcount;
      int lat;
      logic [31:0] d;
      errors  = 0;
      checks  = 0;
      rst     = 1'b1;
      start   = 1'b0;
      data_in = 32'd0;
      shamt   = 5'd0;
      tick();
      tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      rst = 1'b0;
      tick();

      // Abort mid-SHIFT with a 2-cycle reset.
      start   = 1'b1;
      data_in = 32'hFFFF_FFFF;
      shamt   = 5'd20;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_result", result, 32'd0);
      dcount = 0;
      for (int i = 0; i < 30; i++) begin
         if (done === 1'b1) dcount++;
         tick();
      end
      check("abort_no_done", 32'(dcount), 32'd0);
      check("abort_result_after", result, 32'd0);

      run_op("sh0", 32'h1234_5678, 0, 32'h1234_5678);
      run_op("sh4", 32'h0000_ABCD, 4, 32'h000A_BCD0);
      run_op("sh31", 32'h0000_0003, 31, 32'h8000_0000);
      run_op("sh1_msb", 32'hC000_0001, 1, 32'h8000_0002);

      // Back-to-back: second start issued during the DONE cycle of the first.
      start   = 1'b1;
      data_in = 32'h0000_0001;
      shamt   = 5'd1;
      tick();
      start = 1'b0;
      tick();
      check("b2b_first_done", {31'd0, done}, 32'd1);
      check("b2b_first_res", result, 32'h0000_0002);
      start   = 1'b1;
      data_in = 32'h8000_0001;
      shamt   = 5'd1;
      tick();
      start   = 1'b0;
      data_in = 32'd0;
      check("b2b_no_idle_busy", {31'd0, busy}, 32'd1);
      check("b2b_mid_done", {31'd0, done}, 32'd0);
      check("b2b_mid_hold", result, 32'h0000_0002);
      tick();
      check("b2b_second_done", {31'd0, done}, 32'd1);
      check("b2b_second_res", result, 32'h0000_0002);
      tick();
      check("b2b_idle_done", {31'd0, done}, 32'd0);

      // Start pulsed during SHIFT must be ignored.
      start   = 1'b1;
      data_in = 32'h0000_00F1;
      shamt   = 5'd8;
      tick();
      start = 1'b0;
      tick();
      tick();
      start   = 1'b1;
      data_in = 32'hFFFF_FFFF;
      shamt   = 5'd1;
      tick();
      start   = 1'b0;
      data_in = 32'd0;
      lat     = 3;
      dcount  = 0;
      while (done !== 1'b1 && lat < 64) begin
         tick();
         lat++;
      end
      check("ign_lat", 32'(lat), 32'd8);
      check("ign_res", result, 32'h0000_F100);
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) dcount++;
         tick();
      end
      check("ign_single_done", 32'(dcount), 32'd1);

      // Sweep every shift amount against the << model.
      for (int sh = 0; sh < 32; sh++) begin
         d = $urandom;
         run_op($sformatf("sweep%0d", sh), d, sh, d << sh);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_seq_shift_left
